// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush control for the five-stage MIPS core.
// Sources: load-use, ID branch operands, multi-cycle MDU, data memory.
module pipe_ctrl #(
  parameter int NSTAGE     = 6,
  parameter int REG_W      = 5,
  parameter int MDU_LAT    = 32,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic [REG_W-1:0]  exe_reg,
  input  logic              exe_write_regfile,
  input  logic              exe_mem_to_regfile,
  input  logic              exe_mdu_start,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MCW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam bit MDU_MULTI = (MDU_LAT > 1);
  localparam bit NO_DS = (DELAY_SLOT == 0);
  // Start cycle is the first stall, so BUSY needs MDU_LAT-2 more.
  localparam logic [MCW-1:0] MLOAD =
    MDU_MULTI ? MCW'(MDU_LAT - 2) : '0;

  typedef enum logic {M_IDLE, M_BUSY} mstate_t;
  typedef enum logic {D_IDLE, D_WAIT} dstate_t;

  mstate_t          r_mstate;
  dstate_t          r_dstate;
  logic [MCW-1:0]   r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_src_hit;
  logic w_lu_hz;
  logic w_br_hz;
  logic w_id_hz;
  logic w_mdu_wait;
  logic w_mem_wait;

  function automatic logic f_match(
    input logic [REG_W-1:0] a,
    input logic             u,
    input logic [REG_W-1:0] d
  );
    return u && (a != '0) && (a == d);
  endfunction

  assign w_src_hit = f_match(id_rs, id_use_rs, exe_reg)
                   | f_match(id_rt, id_use_rt, exe_reg);
  assign w_lu_hz = exe_mem_to_regfile && w_src_hit;
  assign w_br_hz = id_is_branch && exe_write_regfile
                && w_src_hit;
  assign w_id_hz = w_lu_hz || w_br_hz;

  assign w_mdu_wait =
    (r_mstate == M_IDLE && exe_mdu_start && MDU_MULTI)
    || (r_mstate == M_BUSY && r_cnt != '0);
  assign w_mem_wait = mem_req && !mem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mstate <= M_IDLE;
      r_cnt    <= '0;
    end else begin
      unique case (r_mstate)
        M_IDLE: begin
          if (exe_mdu_start && MDU_MULTI) begin
            r_mstate <= M_BUSY;
            r_cnt    <= MLOAD;
          end
        end
        M_BUSY: begin
          if (r_cnt == '0) r_mstate <= M_IDLE;
          else r_cnt <= r_cnt - MCW'(1);
        end
        default: r_mstate <= M_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dstate <= D_IDLE;
    end else if (r_dstate == D_IDLE) begin
      if (w_mem_wait) r_dstate <= D_WAIT;
    end else if (mem_ack) begin
      r_dstate <= D_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_stall_cnt <= '0;
    else if (stall[0]) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  always_comb begin
    stall = '0;
    flush = '0;
    if (w_mem_wait) begin
      stall[3:0] = '1;
      flush[4]   = 1'b1;
    end else if (w_mdu_wait) begin
      stall[2:0] = '1;
      flush[3]   = 1'b1;
    end else if (w_id_hz) begin
      stall[1:0] = '1;
      flush[2]   = 1'b1;
    end
    flush[1] = id_branch_taken && NO_DS && !stall[1];
  end

  assign mdu_busy  = w_mdu_wait;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl.
// MDU_LAT=4, DELAY_SLOT=0 configuration.
module tb_pipe_ctrl;

  localparam int NS = 6;
  localparam int RW = 5;
  localparam int CW = 32;

  localparam logic [NS-1:0] S_LU = 6'b000011;
  localparam logic [NS-1:0] F_LU = 6'b000100;
  localparam logic [NS-1:0] S_MD = 6'b000111;
  localparam logic [NS-1:0] F_MD = 6'b001000;
  localparam logic [NS-1:0] S_ME = 6'b001111;
  localparam logic [NS-1:0] F_ME = 6'b010000;
  localparam logic [NS-1:0] F_BR = 6'b000010;
  localparam logic [NS-1:0] Z    = 6'b000000;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, exe_reg;
  logic          id_use_rs, id_use_rt;
  logic          id_is_branch, id_branch_taken;
  logic          exe_write_regfile, exe_mem_to_regfile;
  logic          exe_mdu_start, mem_req, mem_ack;
  logic [NS-1:0] stall, flush;
  logic          mdu_busy;
  logic [CW-1:0] stall_cnt;

  typedef struct {
    string         tag;
    logic [NS-1:0] s;
    logic [NS-1:0] f;
    logic          b;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .NSTAGE(NS), .REG_W(RW), .MDU_LAT(4),
    .DELAY_SLOT(0), .CNT_W(CW)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .id_is_branch(id_is_branch),
    .id_branch_taken(id_branch_taken),
    .exe_reg(exe_reg),
    .exe_write_regfile(exe_write_regfile),
    .exe_mem_to_regfile(exe_mem_to_regfile),
    .exe_mdu_start(exe_mdu_start),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .stall(stall),
    .flush(flush),
    .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  task automatic clear_in();
    id_rs = '0; id_rt = '0; exe_reg = '0;
    id_use_rs = 0; id_use_rt = 0;
    id_is_branch = 0; id_branch_taken = 0;
    exe_write_regfile = 0; exe_mem_to_regfile = 0;
    exe_mdu_start = 0; mem_req = 0; mem_ack = 0;
  endtask

  // Inputs are already driven for this cycle; check mid-cycle,
  // then move to just after the next rising edge.
  task automatic step(input string tag, input logic [NS-1:0] es,
                      input logic [NS-1:0] ef, input logic eb);
    exp_t e;
    e.tag = tag; e.s = es; e.f = ef; e.b = eb;
    q.push_back(e);
    @(negedge clk);
    n_assert++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      assert (stall === e.s) else begin
        n_fail++;
        $error("FAIL %s stall: observed %b expected %b",
               e.tag, stall, e.s);
      end
      n_assert++;
      assert (flush === e.f) else begin
        n_fail++;
        $error("FAIL %s flush: observed %b expected %b",
               e.tag, flush, e.f);
      end
      n_assert++;
      assert (mdu_busy === e.b) else begin
        n_fail++;
        $error("FAIL %s mdu_busy: observed %b expected %b",
               e.tag, mdu_busy, e.b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] ex);
    n_assert++;
    assert (stall_cnt === ex) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d",
             tag, stall_cnt, ex);
    end
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step("reset", Z, Z, 0);
    chk_cnt("reset", 0);

    exe_reg = 5'd3; exe_mem_to_regfile = 1; exe_write_regfile = 1;
    id_rs = 5'd3; id_use_rs = 1;
    step("lu", S_LU, F_LU, 0);
    chk_cnt("lu", 1);
    exe_mem_to_regfile = 0; exe_write_regfile = 0;
    step("lu_rel", Z, Z, 0);

    exe_reg = 5'd0; exe_mem_to_regfile = 1; id_rs = 5'd0;
    step("lu_r0", Z, Z, 0);
    exe_reg = 5'd3; id_rs = 5'd0; id_use_rs = 0;
    id_rt = 5'd3; id_use_rt = 0;
    step("lu_nouse", Z, Z, 0);
    id_use_rt = 1;
    step("lu_rt", S_LU, F_LU, 0);
    clear_in();
    chk_cnt("lu_rt", 2);

    exe_mdu_start = 1;
    step("mdu1", S_MD, F_MD, 1);
    step("mdu2", S_MD, F_MD, 1);
    step("mdu3", S_MD, F_MD, 1);
    step("mdu_rel", Z, Z, 0);
    chk_cnt("mdu", 5);
    exe_mdu_start = 0;
    step("mdu_idle", Z, Z, 0);

    mem_req = 1;
    step("mem1", S_ME, F_ME, 0);
    step("mem2", S_ME, F_ME, 0);
    mem_ack = 1;
    step("mem_ack", Z, Z, 0);
    chk_cnt("mem", 7);
    clear_in();
    step("mem_idle", Z, Z, 0);

    exe_mdu_start = 1;
    step("ov_mdu", S_MD, F_MD, 1);
    mem_req = 1;
    exe_reg = 5'd7; exe_mem_to_regfile = 1;
    id_rs = 5'd7; id_use_rs = 1;
    step("ov_mem1", S_ME, F_ME, 1);
    step("ov_mem2", S_ME, F_ME, 1);
    mem_ack = 1; exe_mem_to_regfile = 0;
    step("ov_rel", Z, Z, 0);
    clear_in();
    step("ov_idle", Z, Z, 0);
    chk_cnt("ov", 10);

    id_branch_taken = 1;
    step("br", Z, F_BR, 0);
    id_is_branch = 1; exe_write_regfile = 1;
    exe_reg = 5'd5; id_rt = 5'd5; id_use_rt = 1;
    step("br_hz", S_LU, F_LU, 0);
    exe_write_regfile = 0;
    step("br_clr", Z, F_BR, 0);
    mem_req = 1;
    step("br_mem", S_ME, F_ME, 0);
    clear_in();
    chk_cnt("br", 12);

    exe_mdu_start = 1;
    step("rst_mdu1", S_MD, F_MD, 1);
    step("rst_mdu2", S_MD, F_MD, 1);
    reset = 1'b1; exe_mdu_start = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("rst_after", Z, Z, 0);
    chk_cnt("rst_after", 0);
    step("rst_after2", Z, Z, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
